// File: rtl/instruction_fetch_if.sv
// Fetch-stage bundle: instruction-memory request/response, redirect input and
// the registered instruction handed to decode.
interface instruction_fetch_if;
    logic        stall;
    logic        redirect;
    logic [31:0] redirectPc;
    logic        imemReq;
    logic [31:0] imemAddr;
    logic        imemReady;
    logic [31:0] imemRdata;
    logic [31:0] instOut;
    logic [6:0]  opcodeOut;
    logic [31:0] pcOut;
    logic        validOut;

    // master: the fetch unit itself
    modport master (
        input  stall, redirect, redirectPc, imemReady, imemRdata,
        output imemReq, imemAddr, instOut, opcodeOut, pcOut, validOut
    );

    // slave: memory / pipeline environment around the fetch unit
    modport slave (
        output stall, redirect, redirectPc, imemReady, imemRdata,
        input  imemReq, imemAddr, instOut, opcodeOut, pcOut, validOut
    );
endinterface

// File: rtl/instruction_fetch.sv
// Instruction fetch stage: one outstanding memory request, a one-entry skid
// buffer to absorb a response that arrives while decode is stalled, and redirect.
module instruction_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                  clk,
    input  logic                  rst,
    instruction_fetch_if.master   bus
);

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {IDLE, REQ, DRAIN} state_t;

    state_t      state_reg;
    logic        req_reg;
    logic [31:0] pc_reg;
    logic [31:0] req_addr_reg;
    logic [31:0] skid_inst_reg;
    logic [31:0] skid_pc_reg;
    logic        skid_valid_reg;
    logic [31:0] inst_reg;
    logic [31:0] pc_out_reg;
    logic        valid_reg;

    logic        accept;
    logic        fire;
    logic [31:0] pc_plus4;
    logic [31:0] redirect_target;
    logic        unused_low_bits;

    assign accept          = !valid_reg || !bus.stall;
    assign fire            = (state_reg == REQ) && bus.imemReady;
    assign pc_plus4        = pc_reg + 32'd4;
    assign redirect_target = {bus.redirectPc[31:2], 2'b00};
    assign unused_low_bits = ^bus.redirectPc[1:0];

    assign bus.imemReq   = req_reg;
    assign bus.imemAddr  = req_addr_reg;
    assign bus.instOut   = inst_reg;
    assign bus.opcodeOut = inst_reg[6:0];
    assign bus.pcOut     = pc_out_reg;
    assign bus.validOut  = valid_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= IDLE;
            req_reg        <= 1'b0;
            pc_reg         <= RESET_PC;
            req_addr_reg   <= RESET_PC;
            skid_inst_reg  <= NOP;
            skid_pc_reg    <= RESET_PC;
            skid_valid_reg <= 1'b0;
            inst_reg       <= NOP;
            pc_out_reg     <= RESET_PC;
            valid_reg      <= 1'b0;
        end else if (bus.redirect) begin
            // Redirect flushes everything; an in-flight request must still
            // complete before a new address may be presented.
            pc_reg         <= redirect_target;
            valid_reg      <= 1'b0;
            skid_valid_reg <= 1'b0;
            req_reg        <= 1'b1;
            if (state_reg != IDLE && !bus.imemReady) begin
                state_reg <= DRAIN;
            end else begin
                state_reg    <= REQ;
                req_addr_reg <= redirect_target;
            end
        end else begin
            // Output register: skid entry first, then fresh memory data.
            if (accept) begin
                if (skid_valid_reg) begin
                    inst_reg       <= skid_inst_reg;
                    pc_out_reg     <= skid_pc_reg;
                    valid_reg      <= 1'b1;
                    skid_valid_reg <= 1'b0;
                end else if (fire) begin
                    inst_reg   <= bus.imemRdata;
                    pc_out_reg <= req_addr_reg;
                    valid_reg  <= 1'b1;
                end else begin
                    valid_reg <= 1'b0;
                end
            end

            case (state_reg)
                IDLE: begin
                    if (!skid_valid_reg || accept) begin
                        state_reg    <= REQ;
                        req_reg      <= 1'b1;
                        req_addr_reg <= pc_reg;
                    end
                end
                REQ: begin
                    if (bus.imemReady) begin
                        pc_reg       <= pc_plus4;
                        req_addr_reg <= pc_plus4;
                        // Response that cannot go straight out parks in the skid
                        // and fetching pauses until the skid drains.
                        if (!(accept && !skid_valid_reg)) begin
                            skid_inst_reg  <= bus.imemRdata;
                            skid_pc_reg    <= req_addr_reg;
                            skid_valid_reg <= 1'b1;
                            state_reg      <= IDLE;
                            req_reg        <= 1'b0;
                        end
                    end
                end
                DRAIN: begin
                    if (bus.imemReady) begin
                        state_reg    <= REQ;
                        req_addr_reg <= pc_reg;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    req_reg   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: reset, streaming, stall/skid, redirect
// with slow memory, PC wrap and reset during drain.
module tb_instruction_fetch;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    instruction_fetch_if bus ();

    instruction_fetch #(.RESET_PC(32'h0000_0000)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0) return 32'h0000_0517;
        return a ^ 32'h5A5A_0000;
    endfunction

    assign bus.imemRdata = mem_word(bus.imemAddr);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
        $display("check %-14s observed=%h expected=%h", tag, obs, exp);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        bus.stall = 1'b0;
        bus.redirect = 1'b0;
        bus.redirectPc = 32'h0;
        bus.imemReady = 1'b0;
        tick();
        tick();
        chk("rst_req",    {31'd0, bus.imemReq},  32'd0);
        chk("rst_valid",  {31'd0, bus.validOut}, 32'd0);
        chk("rst_inst",   bus.instOut,           32'h0000_0013);
        chk("rst_pcout",  bus.pcOut,             32'h0);
        chk("rst_opcode", {25'd0, bus.opcodeOut}, 32'h13);

        // Streaming with zero-wait memory
        rst = 1'b0;
        bus.imemReady = 1'b1;
        tick();
        chk("e1_req",   {31'd0, bus.imemReq},  32'd1);
        chk("e1_addr",  bus.imemAddr,          32'h0);
        chk("e1_valid", {31'd0, bus.validOut}, 32'd0);
        tick();
        chk("e2_addr",   bus.imemAddr,           32'h4);
        chk("e2_pcout",  bus.pcOut,              32'h0);
        chk("e2_inst",   bus.instOut,            32'h0000_0517);
        chk("e2_opcode", {25'd0, bus.opcodeOut}, 32'h17);
        chk("e2_valid",  {31'd0, bus.validOut},  32'd1);
        tick();
        chk("e3_addr",  bus.imemAddr, 32'h8);
        chk("e3_pcout", bus.pcOut,    32'h4);
        chk("e3_inst",  bus.instOut,  32'h5A5A_0004);

        // Stall for three cycles while the response for 8 returns
        bus.stall = 1'b1;
        tick();
        chk("s1_req",   {31'd0, bus.imemReq}, 32'd0);
        chk("s1_pcout", bus.pcOut,            32'h4);
        chk("s1_inst",  bus.instOut,          32'h5A5A_0004);
        tick();
        chk("s2_req",   {31'd0, bus.imemReq}, 32'd0);
        chk("s2_pcout", bus.pcOut,            32'h4);
        tick();
        chk("s3_req",   {31'd0, bus.imemReq},  32'd0);
        chk("s3_valid", {31'd0, bus.validOut}, 32'd1);
        bus.stall = 1'b0;
        tick();
        chk("sk_pcout", bus.pcOut,            32'h8);
        chk("sk_inst",  bus.instOut,          32'h5A5A_0008);
        chk("sk_req",   {31'd0, bus.imemReq}, 32'd1);
        chk("sk_addr",  bus.imemAddr,         32'hC);
        tick();
        chk("rs_pcout", bus.pcOut,    32'hC);
        chk("rs_inst",  bus.instOut,  32'h5A5A_000C);
        chk("rs_addr",  bus.imemAddr, 32'h10);

        // Slow memory, redirect to 0x103 while request to 0x10 is pending
        bus.imemReady = 1'b0;
        tick();
        chk("w1_addr",  bus.imemAddr,          32'h10);
        chk("w1_valid", {31'd0, bus.validOut}, 32'd0);
        bus.redirect = 1'b1;
        bus.redirectPc = 32'h0000_0103;
        tick();
        bus.redirect = 1'b0;
        chk("rd_req",   {31'd0, bus.imemReq},  32'd1);
        chk("rd_addr",  bus.imemAddr,          32'h10);
        chk("rd_valid", {31'd0, bus.validOut}, 32'd0);
        bus.imemReady = 1'b1;
        tick();
        bus.imemReady = 1'b0;
        chk("dr_addr",  bus.imemAddr,          32'h100);
        chk("dr_valid", {31'd0, bus.validOut}, 32'd0);
        tick();
        chk("n1_addr",  bus.imemAddr,          32'h100);
        chk("n1_valid", {31'd0, bus.validOut}, 32'd0);
        tick();
        chk("n2_valid", {31'd0, bus.validOut}, 32'd0);
        bus.imemReady = 1'b1;
        tick();
        chk("n3_pcout", bus.pcOut,             32'h100);
        chk("n3_inst",  bus.instOut,           32'h5A5A_0100);
        chk("n3_valid", {31'd0, bus.validOut}, 32'd1);
        chk("n3_addr",  bus.imemAddr,          32'h104);

        // Redirect to the top word, fetch wraps to 0
        bus.redirect = 1'b1;
        bus.redirectPc = 32'hFFFF_FFFC;
        tick();
        bus.redirect = 1'b0;
        chk("wr_addr",  bus.imemAddr,          32'hFFFF_FFFC);
        chk("wr_valid", {31'd0, bus.validOut}, 32'd0);
        tick();
        chk("wr_pcout", bus.pcOut,    32'hFFFF_FFFC);
        chk("wr_inst",  bus.instOut,  32'hA5A5_FFFC);
        chk("wr_next",  bus.imemAddr, 32'h0);
        tick();
        chk("wz_pcout", bus.pcOut,   32'h0);
        chk("wz_inst",  bus.instOut, 32'h0000_0517);

        // Redirects into DRAIN, then asynchronous reset
        bus.imemReady = 1'b0;
        bus.redirect = 1'b1;
        bus.redirectPc = 32'h0000_0040;
        tick();
        chk("d1_req",  {31'd0, bus.imemReq}, 32'd1);
        chk("d1_addr", bus.imemAddr,         32'h4);
        bus.redirectPc = 32'h0000_0080;
        tick();
        bus.redirect = 1'b0;
        chk("d2_addr",  bus.imemAddr,          32'h4);
        chk("d2_valid", {31'd0, bus.validOut}, 32'd0);
        rst = 1'b1;
        #1;
        chk("ar_req",   {31'd0, bus.imemReq},  32'd0);
        chk("ar_valid", {31'd0, bus.validOut}, 32'd0);
        chk("ar_inst",  bus.instOut,           32'h0000_0013);
        tick();
        rst = 1'b0;
        tick();
        chk("pr_req",   {31'd0, bus.imemReq},  32'd1);
        chk("pr_addr",  bus.imemAddr,          32'h0);
        chk("pr_valid", {31'd0, bus.validOut}, 32'd0);
        bus.imemReady = 1'b1;
        tick();
        chk("pr_pcout", bus.pcOut,             32'h0);
        chk("pr_inst",  bus.instOut,           32'h0000_0517);
        chk("pr_vout",  {31'd0, bus.validOut}, 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, SHALL be the first fetch address after reset; bits [1:0] SHALL be 0.
REQ-002 Port clk, input, 1, SHALL be the single clock; all state updates on the rising edge.
REQ-003 Port rst, input, 1, SHALL be the reset: asynchronous and active-high.
REQ-004 Port stall, input, 1, SHALL mean downstream (decode/immediate extension) cannot accept instOut this cycle.
REQ-005 Port redirect, input, 1, SHALL be a one-cycle pulse requesting a fetch from redirectPc (branch, JAL or JALR taken).
REQ-006 Port redirectPc, input, 32, SHALL be the redirect target; bits [1:0] are ignored and treated as 0.
REQ-007 Port imemReq, output, 1, SHALL be the instruction-memory request strobe.
REQ-008 Port imemAddr, output, 32, SHALL be the word-aligned request address.
REQ-009 Port imemReady, input, 1, SHALL mean imemRdata is valid for the current request this cycle.
REQ-010 Port imemRdata, input, 32, SHALL be the instruction word returned by memory.
REQ-011 Port instOut, output, 32, SHALL be the registered instruction word for decode.
REQ-012 Port opcodeOut, output, 7, SHALL equal instOut[6:0] combinationally.
REQ-013 Port pcOut, output, 32, SHALL be the address instOut was fetched from.
REQ-014 Port validOut, output, 1, SHALL mean instOut/pcOut hold a live instruction.

Function
REQ-015 Internal state SHALL be: pc (next fetch address), reqAddr, a one-entry skid buffer {skidInst, skidPc, skidValid}, and FSM state in {IDLE, REQ, DRAIN}.
REQ-016 accept SHALL be defined as (!validOut || !stall); the output register loads only when accept=1.
REQ-017 imemReq SHALL be 1 exactly in states REQ and DRAIN, and imemAddr SHALL equal reqAddr, held stable until imemReady.
REQ-018 IDLE -> REQ SHALL occur when skidValid=0 at the clock edge (next-state value), with reqAddr <= pc.
REQ-019 In REQ with imemReady=1 and redirect=0: pc <= pc+4 (modulo 2^32, 32'hFFFF_FFFC wraps to 0), reqAddr <= pc+4.
REQ-020 In case REQ-019, if accept=1 and skidValid=0 the output SHALL load {imemRdata, reqAddr}, validOut <= 1, and the FSM stays in REQ; otherwise {imemRdata, reqAddr} SHALL go to the skid buffer and the FSM goes to IDLE.
REQ-021 When accept=1 and skidValid=1, the output SHALL load from the skid buffer and skidValid <= 0; the skid buffer has priority over new memory data.
REQ-022 When accept=1 and no data is available (no skid entry, no imemReady in REQ), validOut SHALL go to 0.
REQ-023 Latency: fetch-to-instOut SHALL be one cycle after imemReady; with zero-wait memory and no stall, throughput SHALL be one instruction per cycle.
REQ-024 redirect=1 SHALL take priority over all other events: pc <= {redirectPc[31:2],2'b00}, validOut <= 0, skidValid <= 0, and any imemRdata this cycle is discarded.
REQ-025 On redirect in REQ with imemReady=0, the FSM SHALL go to DRAIN; otherwise it SHALL go to REQ with reqAddr <= the new pc.
REQ-026 In DRAIN, the returned data SHALL be discarded on imemReady, then the FSM goes to REQ with reqAddr <= pc; a further redirect in DRAIN updates pc and stays in DRAIN.
REQ-027 stall SHALL hold instOut, pcOut and validOut unchanged while validOut=1.

Reset
REQ-028 While rst=1: FSM=IDLE, pc=RESET_PC, reqAddr=RESET_PC, imemReq=0, validOut=0, skidValid=0, instOut=32'h0000_0013 (NOP), pcOut=RESET_PC.
REQ-029 Reset asserted mid-request SHALL abandon the request; the first post-reset request SHALL be to RESET_PC on the cycle after rst falls.

Verification
REQ-030 Reset release, imemReady tied 1, no stall -> imemAddr 0,4,8 on consecutive cycles; pcOut 0,4,8 one cycle later, validOut=1.
REQ-031 imemRdata=32'h0000_0517 (AUIPC) at PC 0 -> instOut=32'h0000_0517, opcodeOut=7'h17, pcOut=0.
REQ-032 stall=1 for 3 cycles while one response returns -> instOut frozen, response captured in skid, imemReq=0; after stall drops, skid instruction appears next, then fetch resumes in order.
REQ-033 Memory with 3-cycle latency, redirect to 32'h0000_0103 one cycle into request -> old address held until ready, data discarded, next imemAddr=32'h0000_0100, validOut=0 until its data returns.
REQ-034 redirectPc=32'hFFFF_FFFC then zero-wait fetch -> pcOut FFFF_FFFC, then 0000_0000.
REQ-035 rst pulsed while in DRAIN -> imemReq=0 immediately, first request after release is to RESET_PC, validOut=0.
